// File: rtl/lsu_data_memory.sv
// RV32I load/store data memory: byte lanes, sign extension, error responses.
// Latency LATENCY cycles accept-to-response; req_ready low while waiting, no response backpressure.
module lsu_data_memory #(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] hold_q, hold_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;
    logic        we_q, we_d;
    logic        err_q, err_d;

    logic                  accept;
    logic                  range_err, align_err, op_err, req_err;
    logic [IDX_W-1:0]      idx;
    logic [1:0]            lane;
    logic [3:0]            wr_be;
    logic [31:0]           wr_lanes;
    logic [31:0]           wr_word;
    logic                  wr_en;
    logic [DEPTH-1:0][31:0] mem_rd;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    assign req_ready = !reset && (state_q != ST_WAIT);
    assign accept    = req_valid && req_ready;
    assign idx       = req_addr[IDX_W+1:2];
    assign lane      = req_addr[1:0];

    // Request decode: every error source is folded into req_err so the write path stays clean.
    always_comb begin
        range_err = |req_addr[ADDR_W-1:IDX_W+2];
        align_err = 1'b0;
        case (req_funct3[1:0])
            2'b01:   align_err = req_addr[0];
            2'b10:   align_err = |req_addr[1:0];
            default: align_err = 1'b0;
        endcase
        if (req_we) begin
            op_err = (req_funct3 >= 3'b011);
        end else begin
            op_err = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        req_err = range_err || align_err || op_err;
    end

    always_comb begin
        wr_be    = 4'b0000;
        wr_lanes = 32'h0;
        if (accept && req_we && !req_err) begin
            case (req_funct3)
                3'b000: begin
                    wr_be    = 4'b0001 << lane;
                    wr_lanes = {4{req_wdata[7:0]}};
                end
                3'b001: begin
                    wr_be    = lane[1] ? 4'b1100 : 4'b0011;
                    wr_lanes = {2{req_wdata[15:0]}};
                end
                3'b010: begin
                    wr_be    = 4'b1111;
                    wr_lanes = req_wdata;
                end
                default: begin
                    wr_be    = 4'b0000;
                    wr_lanes = 32'h0;
                end
            endcase
        end
        wr_en = |wr_be;
        for (int b = 0; b < 4; b++) begin
            wr_word[8*b +: 8] = wr_be[b] ? wr_lanes[8*b +: 8] : mem_rd[idx][8*b +: 8];
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        logic [31:0] word_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                word_q <= 32'h0;
            end else if (wr_en && (idx == IDX_W'(gi))) begin
                word_q <= wr_word;
            end
        end
        assign mem_rd[gi] = word_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        funct3_d = funct3_q;
        lane_d   = lane_q;
        we_d     = we_q;
        err_d    = err_q;
        if (accept) begin
            hold_d   = mem_rd[idx];
            funct3_d = req_funct3;
            lane_d   = lane;
            we_d     = req_we;
            err_d    = req_err;
            cnt_d    = 2'(LATENCY - 1);
            state_d  = (LATENCY > 1) ? ST_WAIT : ST_RESP;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    cnt_d = cnt_q - 2'd1;
                    // Leave WAIT on the edge where the counter reaches zero.
                    if (cnt_q <= 2'd1) begin
                        cnt_d   = 2'd0;
                        state_d = ST_RESP;
                    end
                end
                ST_RESP: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 2'd0;
            hold_q   <= 32'h0;
            funct3_q <= 3'b000;
            lane_q   <= 2'b00;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            funct3_q <= funct3_d;
            lane_q   <= lane_d;
            we_q     <= we_d;
            err_q    <= err_d;
        end
    end

    assign byte_sel = hold_q[8*lane_q +: 8];
    assign half_sel = lane_q[1] ? hold_q[31:16] : hold_q[15:0];

    always_comb begin
        rsp_valid = !reset && (state_q == ST_RESP);
        rsp_rdata = 32'h0;
        rsp_err   = 1'b0;
        if (rsp_valid) begin
            rsp_err = err_q;
            if (!err_q && !we_q) begin
                case (funct3_q)
                    3'b000:  rsp_rdata = {{24{byte_sel[7]}}, byte_sel};
                    3'b001:  rsp_rdata = {{16{half_sel[15]}}, half_sel};
                    3'b010:  rsp_rdata = hold_q;
                    3'b100:  rsp_rdata = {24'h0, byte_sel};
                    3'b101:  rsp_rdata = {16'h0, half_sel};
                    default: rsp_rdata = 32'h0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lsu_data_memory.sv
// Directed bench: a LATENCY=1 instance for data paths/errors, a LATENCY=3 instance for pacing and reset.
module tb_lsu_data_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    // LATENCY=1, DEPTH=128 instance
    logic        rst1, v1, rdy1, we1, rv1, re1;
    logic [31:0] a1, wd1, rd1;
    logic [2:0]  f1;
    // LATENCY=3, DEPTH=64 instance
    logic        rst3, v3, rdy3, we3, rv3, re3;
    logic [31:0] a3, wd3, rd3;
    logic [2:0]  f3;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    lsu_data_memory #(.ADDR_W(32), .DEPTH(128), .LATENCY(1)) dut1 (
        .clk(clk), .reset(rst1), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
        .req_addr(a1), .req_funct3(f1), .req_wdata(wd1),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1)
    );

    lsu_data_memory #(.ADDR_W(32), .DEPTH(64), .LATENCY(3)) dut3 (
        .clk(clk), .reset(rst3), .req_valid(v3), .req_ready(rdy3), .req_we(we3),
        .req_addr(a3), .req_funct3(f3), .req_wdata(wd3),
        .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(re3)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rv1) begin
            chk1("sb1_pending", q1.size() != 0, 1'b1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                chk32("rsp1_rdata", rd1, e1.rdata);
                chk1("rsp1_err", re1, e1.err);
            end
        end
        if (rv3) begin
            chk1("sb3_pending", q3.size() != 0, 1'b1);
            if (q3.size() != 0) begin
                e3 = q3.pop_front();
                chk32("rsp3_rdata", rd3, e3.rdata);
                chk1("rsp3_err", re3, e3.err);
            end
        end
    end

    task automatic issue1(input logic we, input logic [31:0] addr, input logic [2:0] fn,
                          input logic [31:0] wd, input logic [31:0] er, input logic ee);
        int w;
        @(negedge clk);
        chk1("rsp1_idle_valid", rv1, 1'b0);
        chk32("rsp1_idle_rdata", rd1, 32'h0);
        v1 = 1'b1; we1 = we; a1 = addr; f1 = fn; wd1 = wd;
        w = 0;
        while (!rdy1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        chk1("rdy1_before_accept", rdy1, 1'b1);
        @(posedge clk);
        q1.push_back(exp_t'({er, ee}));
        @(negedge clk);
        v1 = 1'b0;
        chk1("rsp1_latency", rv1, 1'b1);
    endtask

    logic        l3_we   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] l3_addr [4] = '{32'h8, 32'h8, 32'h9, 32'h8};
    logic [2:0]  l3_fn   [4] = '{3'b010, 3'b010, 3'b000, 3'b010};
    logic [31:0] l3_wd   [4] = '{32'hA5A5A5A5, 32'h0, 32'h0000007F, 32'h0};
    logic [31:0] l3_exp  [4] = '{32'h0, 32'hA5A5A5A5, 32'h0, 32'hA5A57FA5};

    initial begin
        int idx;
        int w;
        logic acc;
        rst1 = 1'b1; v1 = 1'b0; we1 = 1'b0; a1 = '0; f1 = '0; wd1 = '0;
        rst3 = 1'b1; v3 = 1'b0; we3 = 1'b0; a3 = '0; f3 = '0; wd3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("reset_ready", rdy1, 1'b0);
        chk1("reset_valid", rv1, 1'b0);
        chk32("reset_rdata", rd1, 32'h0);
        chk1("reset_err", re1, 1'b0);
        chk1("reset_ready3", rdy3, 1'b0);
        rst1 = 1'b0; rst3 = 1'b0;
        #1;
        chk1("ready_after_reset", rdy1, 1'b1);

        issue1(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0);
        issue1(1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);
        issue1(1'b1, 32'h21, 3'b000, 32'h00000080, 32'h0, 1'b0);
        issue1(1'b0, 32'h21, 3'b000, 32'h0, 32'hFFFFFF80, 1'b0);
        issue1(1'b0, 32'h21, 3'b100, 32'h0, 32'h00000080, 1'b0);
        issue1(1'b0, 32'h20, 3'b010, 32'h0, 32'h00008000, 1'b0);
        issue1(1'b1, 32'h32, 3'b001, 32'h00008001, 32'h0, 1'b0);
        issue1(1'b0, 32'h32, 3'b001, 32'h0, 32'hFFFF8001, 1'b0);
        issue1(1'b0, 32'h32, 3'b101, 32'h0, 32'h00008001, 1'b0);
        issue1(1'b0, 32'h30, 3'b010, 32'h0, 32'h80010000, 1'b0);
        issue1(1'b1, 32'h100, 3'b010, 32'h12345678, 32'h0, 1'b0);
        issue1(1'b0, 32'h102, 3'b010, 32'h0, 32'h0, 1'b1);
        issue1(1'b1, 32'h103, 3'b001, 32'h0000FFFF, 32'h0, 1'b1);
        issue1(1'b0, 32'h200, 3'b010, 32'h0, 32'h0, 1'b1);
        issue1(1'b0, 32'h80000100, 3'b010, 32'h0, 32'h0, 1'b1);
        issue1(1'b0, 32'h100, 3'b011, 32'h0, 32'h0, 1'b1);
        issue1(1'b0, 32'h100, 3'b110, 32'h0, 32'h0, 1'b1);
        issue1(1'b1, 32'h100, 3'b011, 32'hFFFFFFFF, 32'h0, 1'b1);
        issue1(1'b1, 32'h101, 3'b100, 32'hFFFFFFFF, 32'h0, 1'b1);
        issue1(1'b0, 32'h101, 3'b001, 32'h0, 32'h0, 1'b1);
        issue1(1'b0, 32'h100, 3'b010, 32'h0, 32'h12345678, 1'b0);
        issue1(1'b0, 32'h103, 3'b000, 32'h0, 32'h00000012, 1'b0);

        // Four requests with req_valid held high on the LATENCY=3 instance.
        @(negedge clk);
        idx = 0;
        v3 = 1'b1; we3 = l3_we[0]; a3 = l3_addr[0]; f3 = l3_fn[0]; wd3 = l3_wd[0];
        for (int k = 0; k < 12; k++) begin
            chk1("l3_ready_pace", rdy3, (k % 3) == 0);
            acc = v3 && rdy3;
            @(posedge clk);
            if (acc) begin
                q3.push_back(exp_t'({l3_exp[idx], 1'b0}));
                idx++;
            end
            @(negedge clk);
            chk1("l3_valid_pace", rv3, (k % 3) == 2);
            if (acc) begin
                if (idx < 4) begin
                    we3 = l3_we[idx]; a3 = l3_addr[idx]; f3 = l3_fn[idx]; wd3 = l3_wd[idx];
                end else begin
                    v3 = 1'b0;
                end
            end
        end
        chk32("l3_accepts", 32'(idx), 32'd4);

        // Accept a load, then reset before its response is due.
        v3 = 1'b1; we3 = 1'b0; a3 = 32'h8; f3 = 3'b010; wd3 = 32'h0;
        chk1("rst_test_ready", rdy3, 1'b1);
        @(posedge clk);
        @(negedge clk);
        v3 = 1'b0;
        rst3 = 1'b1;
        #1;
        chk1("mid_reset_valid", rv3, 1'b0);
        chk32("mid_reset_rdata", rd3, 32'h0);
        chk1("mid_reset_err", re3, 1'b0);
        chk1("mid_reset_ready", rdy3, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk1("mid_reset_valid_hold", rv3, 1'b0);
        end
        rst3 = 1'b0;
        #1;
        chk1("post_reset_ready", rdy3, 1'b1);
        v3 = 1'b1;
        @(posedge clk);
        q3.push_back(exp_t'({32'h0, 1'b0}));
        @(negedge clk);
        v3 = 1'b0;
        w = 0;
        while (q3.size() != 0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk32("sb3_drained", 32'(q3.size()), 32'd0);
        repeat (2) @(negedge clk);
        chk32("sb1_drained", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
